// File: rtl/pulse_period_meter_if.sv
// Signal bundle for the pulse period meter: control inputs and measurement results.
interface pulse_period_meter_if #(
  parameter int N = 8
);
  logic         ena;
  logic         pulse_in;
  logic [N-1:0] period;
  logic         valid;
  logic         locked;
  logic         timeout;

  modport master (
    output ena,
    output pulse_in,
    input  period,
    input  valid,
    input  locked,
    input  timeout
  );

  modport slave (
    input  ena,
    input  pulse_in,
    output period,
    output valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures the spacing between rising edges of pulse_in in enabled clock cycles,
// flags repeatable measurements (locked) and missing edges (timeout).
module pulse_period_meter #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_period_meter_if.slave   bus
);

  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t       state_r;
  logic         pulse_q_r;
  logic [N-1:0] count_r;
  logic [N-1:0] period_r;
  logic         valid_r;
  logic         locked_r;
  logic         timeout_r;
  logic         have_prev_r;
  logic         edge_s;

  assign edge_s = bus.pulse_in & ~pulse_q_r;

  // Edge-detect history runs regardless of ena so a level held across a freeze is not re-seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q_r <= 1'b0;
    end else begin
      pulse_q_r <= bus.pulse_in;
    end
  end

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      count_r     <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      timeout_r   <= 1'b0;
      have_prev_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (bus.ena) begin
        case (state_r)
          IDLE: begin
            if (edge_s) begin
              count_r <= CNT_ZERO;
              state_r <= MEASURE;
            end
          end
          MEASURE: begin
            // An edge on the saturating cycle still yields a measurement.
            if (edge_s) begin
              period_r    <= count_r;
              valid_r     <= 1'b1;
              locked_r    <= have_prev_r && (count_r == period_r);
              have_prev_r <= 1'b1;
              count_r     <= CNT_ZERO;
            end else if (count_r == CNT_MAX) begin
              state_r   <= TIMEOUT;
              timeout_r <= 1'b1;
              locked_r  <= 1'b0;
            end else begin
              count_r <= count_r + CNT_ONE;
            end
          end
          TIMEOUT: begin
            if (edge_s) begin
              timeout_r   <= 1'b0;
              count_r     <= CNT_ZERO;
              have_prev_r <= 1'b0;
              state_r     <= MEASURE;
            end
          end
          default: begin
            state_r     <= IDLE;
            count_r     <= CNT_ZERO;
            locked_r    <= 1'b0;
            timeout_r   <= 1'b0;
            have_prev_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.period  = period_r;
  assign bus.valid   = valid_r;
  assign bus.locked  = locked_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench: directed table, hand-written corner sequences and random pulse trains
// compared against an elapsed-time reference model.
module tb_pulse_period_meter;

  localparam int N = 8;
  localparam int SAT_GAP = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_period_meter_if #(.N(N)) bus ();

  pulse_period_meter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: remembers the enabled-cycle index of the last edge and derives
  // the period from the elapsed enabled time.
  logic         m_prev;
  bit           m_armed, m_timed, m_have_prev, m_valid, m_locked;
  int           m_idx, m_last;
  logic [N-1:0] m_period;

  function automatic void model_reset();
    m_prev = 1'b0; m_armed = 0; m_timed = 0; m_have_prev = 0;
    m_valid = 0; m_locked = 0; m_idx = 0; m_last = 0; m_period = '0;
  endfunction

  function automatic void model_step(bit e, logic p);
    bit rose;
    int gap;
    rose   = (p === 1'b1) && (m_prev !== 1'b1);
    m_prev = p;
    m_valid = 0;
    if (e) begin
      m_idx++;
      gap = m_idx - m_last;
      if (rose) begin
        if (!m_armed || m_timed) begin
          if (m_timed) m_have_prev = 0;
          m_armed = 1; m_timed = 0; m_last = m_idx;
        end else begin
          m_locked    = m_have_prev && ((gap - 1) == int'(m_period));
          m_period    = N'(gap - 1);
          m_have_prev = 1;
          m_valid     = 1;
          m_last      = m_idx;
        end
      end else if (m_armed && !m_timed && gap >= SAT_GAP) begin
        m_timed  = 1;
        m_locked = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst) model_reset();
    else      model_step(bus.ena, bus.pulse_in);
  end

  task automatic check(string name, logic [N-1:0] e_per, logic e_val, logic e_lck, logic e_to);
    tests++;
    if (bus.period !== e_per || bus.valid !== e_val || bus.locked !== e_lck || bus.timeout !== e_to) begin
      fails++;
      $display("FAIL %s: got period=%0d valid=%b locked=%b timeout=%b, expected period=%0d valid=%b locked=%b timeout=%b",
               name, bus.period, bus.valid, bus.locked, bus.timeout, e_per, e_val, e_lck, e_to);
    end
  endtask

  task automatic apply(bit e, logic p);
    @(negedge clk);
    bus.ena      = e;
    bus.pulse_in = p;
    @(posedge clk);
    #1;
    check("model", m_period, m_valid, m_locked, m_timed);
  endtask

  typedef struct {
    bit           ena;
    logic         pin;
    logic [N-1:0] per;
    logic         val;
    logic         lck;
    logic         to;
  } vec_t;

  vec_t vecs [21];
  int   vcount;

  initial begin
    // Default rows: no pulse, outputs hold; edge rows overwritten below.
    for (int i = 0; i < 21; i++) begin
      vecs[i].ena = 1'b1; vecs[i].pin = 1'b0; vecs[i].val = 1'b0; vecs[i].to = 1'b0;
      vecs[i].per = (i < 6) ? 8'd0 : ((i < 16) ? 8'd5 : 8'd3);
      vecs[i].lck = (i >= 12 && i < 16) ? 1'b1 : 1'b0;
    end
    vecs[0]  = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0};

    bus.ena = 1'b0;
    bus.pulse_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Period and lock with spacing 6 then 4.
    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].ena, vecs[i].pin);
      check($sformatf("table_%0d", i), vecs[i].per, vecs[i].val, vecs[i].lck, vecs[i].to);
    end

    // Timeout after 256 quiet cycles, period retained.
    repeat (255) apply(1'b1, 1'b0);
    check("pre_timeout", 8'd3, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0);
    check("timeout_set", 8'd3, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1);
    check("timeout_clear", 8'd3, 1'b0, 1'b0, 1'b0);
    repeat (5) apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    check("after_timeout", 8'd5, 1'b1, 1'b0, 1'b0);

    // Edge coinciding with counter saturation wins over timeout.
    repeat (255) apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    check("edge_at_max", 8'd255, 1'b1, 1'b0, 1'b0);

    // Wide level produces a single edge.
    repeat (3) apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    vcount = 0;
    for (int i = 1; i < 20; i++) begin
      apply(1'b1, (i < 10) ? 1'b1 : 1'b0);
      if (bus.valid) vcount++;
    end
    tests++;
    if (vcount != 0) begin
      fails++;
      $display("FAIL wide_level_valids: got %0d, expected 0", vcount);
    end
    apply(1'b1, 1'b1);
    check("wide_level_period", 8'd19, 1'b1, 1'b0, 1'b0);

    // Freeze cycles do not count.
    apply(1'b1, 1'b0);
    apply(1'b0, 1'b0); apply(1'b0, 1'b0); apply(1'b0, 1'b0);
    repeat (4) apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    check("ena_gap", 8'd5, 1'b1, 1'b0, 1'b0);

    // Pulse during freeze is ignored.
    apply(1'b1, 1'b0); apply(1'b1, 1'b0);
    apply(1'b0, 1'b1);
    check("frozen_pulse", 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0);
    apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    check("frozen_count", 8'd3, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count.
    repeat (4) apply(1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(1'b1, 1'b1);
    check("rearm_no_valid", 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    check("first_after_rst", 8'd3, 1'b1, 1'b0, 1'b0);

    // Random pulse trains against the model.
    for (int b = 0; b < 40; b++) begin
      int t, reps, w;
      t    = $urandom_range(2, 12);
      reps = $urandom_range(2, 5);
      for (int r = 0; r < reps; r++) begin
        w = $urandom_range(1, t - 1);
        for (int c = 0; c < t; c++)
          apply(($urandom_range(0, 9) != 0), (c < w) ? 1'b1 : 1'b0);
      end
      if ($urandom_range(0, 7) == 0)
        repeat (260) apply(1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter: N, default 8, width of the cycle counter and the period output.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately regardless of clk.
REQ-004 ena  input  1  count enable; when 0, counting and measurement are frozen.
REQ-005 pulse_in  input  1  pulse train to be measured; one-cycle pulses or wider levels are both legal.
REQ-006 period  output  N  last measured period, registered.
REQ-007 valid  output  1  one-cycle strobe marking a new period value.
REQ-008 locked  output  1  high while the last two consecutive measurements are equal.
REQ-009 timeout  output  1  high while no pulse edge has arrived within 2^N-1 enabled cycles.

Function
REQ-010 Edge detection: pulse_q SHALL register pulse_in every cycle, including when ena=0; edge = pulse_in & ~pulse_q.
REQ-011 A level held high for many cycles SHALL produce exactly one edge.
REQ-012 States: IDLE (no reference edge yet), MEASURE (counting since last edge), TIMEOUT (counter saturated).
REQ-013 Edges SHALL be ignored, the counter SHALL hold and valid SHALL stay 0 on any cycle with ena=0.
REQ-014 IDLE + edge (ena=1): counter <= 0, go to MEASURE, valid stays 0.
REQ-015 MEASURE, no edge, counter < 2^N-1: counter <= counter+1.
REQ-016 MEASURE + edge: period <= counter, valid <= 1 for one cycle, counter <= 0, stay in MEASURE.
REQ-017 Period arithmetic: edges D enabled cycles apart give period = D-1, so a source emitting one pulse every T+1 cycles reads period = T.
REQ-018 locked SHALL be set on a MEASURE edge if a previous valid measurement exists and counter equals the current period; otherwise it SHALL be cleared.
REQ-019 MEASURE, no edge, counter == 2^N-1: go to TIMEOUT, timeout <= 1, locked <= 0, counter holds at 2^N-1.
REQ-020 Simultaneous edge and counter == 2^N-1: the edge SHALL win; period <= 2^N-1 with valid, and no timeout is raised.
REQ-021 TIMEOUT + edge: timeout <= 0, counter <= 0, go to MEASURE, valid stays 0; the previous-measurement flag SHALL be cleared.
REQ-022 Outputs update on the same posedge that samples the edge; latency from pulse_in rising to valid is one clock edge.
REQ-023 period SHALL hold its last value between measurements and through TIMEOUT.
REQ-024 Counter and period SHALL be N bits wide; the counter SHALL saturate and never wrap.

Reset
REQ-025 While rst=0: state=IDLE, counter=0, period=0, valid=0, locked=0, timeout=0, pulse_q=0, previous-measurement flag cleared.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; the first edge after release only re-arms the block (IDLE to MEASURE).
REQ-027 rst deassertion SHALL be synchronised by the integrator; the block samples normally from the first posedge with rst=1.

Verification (N=8, ena=1 unless stated)
REQ-028 One-cycle pulses every 6 cycles -> first edge: no valid; second edge: valid, period=5, locked=0; third edge: period=5, locked=1.
REQ-029 Spacing changes from 6 to 4 cycles -> next valid has period=3 and locked=0; the following valid has period=3 and locked=1.
REQ-030 No edge for 256 cycles after a measurement -> timeout=1 when the counter reaches 255, locked=0, period unchanged; next edge clears timeout with no valid; the following edge 6 cycles later gives period=5.
REQ-031 pulse_in held high 10 cycles, then low, with a repeat 20 cycles after the first rise -> exactly one valid, period=19.
REQ-032 Edges 9 cycles apart with ena=0 for 3 of the intervening cycles -> period=5; a pulse arriving while ena=0 -> no valid, counter unchanged.
REQ-033 rst pulsed low asynchronously (between clk edges) mid-count -> all outputs 0 immediately; the first subsequent edge produces no valid.
